// File: rtl/panel_image_loader_if.sv
// Image word stream between the host-side source and the front-panel loader.
interface panel_image_loader_if #(
    parameter int WORD_W = 12
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_last;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/panel_image_loader.sv
// Front-panel image loader: turns (address,data) words into timed load-PC/deposit button presses.
// Optional LOADER_CHECKSUM_EN builds a running sum of deposited data on the checksum output.
module panel_image_loader #(
    parameter int WORD_W    = 12,
    parameter int SETUP_CYC = 10,
    parameter int PULSE_CYC = 10,
    parameter int GAP_CYC   = 10,
    parameter int CNT_W     = WORD_W + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_W-1:0]    start_pc,
    panel_image_loader_if.slave  wr,
    output logic [WORD_W-1:0]    sw,
    output logic                 load_pc_btn,
    output logic                 deposit_btn,
    output logic                 run_sw,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     words_loaded,
    output logic [WORD_W-1:0]    checksum
);

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                             ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                             ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int TIM_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_WORD, OP_SETUP, OP_PULSE, OP_GAP, FINAL_LOAD, DONE
    } state_t;

    function automatic logic [TIM_W-1:0] phase_load(input int n);
        return TIM_W'(n - 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t              state_q, state_d;
    logic [TIM_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   sw_q, sw_d;
    logic                load_btn_q, load_btn_d;
    logic                dep_btn_q, dep_btn_d;
    logic                run_sw_q, run_sw_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic                exp_vld_q, exp_vld_d;
    logic                op_load_q, op_load_d;   // current operation is a PC load
    logic                final_q, final_d;       // current load is the closing start-PC load
    logic [WORD_W-1:0]   exp_pc_q, exp_pc_d;
    logic [WORD_W-1:0]   start_pc_q, start_pc_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                last_q, last_d;

    logic tim_done;
    logic start_acc;
    logic dep_done;

    assign tim_done  = (cnt_q == '0);
    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    assign dep_done  = (state_q == OP_GAP) && tim_done && !op_load_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sw_d       = sw_q;
        run_sw_d   = run_sw_q;
        busy_d     = busy_q;
        done_d     = done_q;
        words_d    = words_q;
        exp_vld_d  = exp_vld_q;
        op_load_d  = op_load_q;
        final_d    = final_q;
        exp_pc_d   = exp_pc_q;
        start_pc_d = start_pc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_acc) begin
                    start_pc_d = start_pc;
                    run_sw_d   = 1'b0;
                    done_d     = 1'b0;
                    words_d    = '0;
                    exp_vld_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                if (wr.wr_valid) begin
                    addr_d  = wr.wr_addr;
                    data_d  = wr.wr_data;
                    last_d  = wr.wr_last;
                    final_d = 1'b0;
                    // Skip the PC load when the panel's auto-increment already points here
                    if (!exp_vld_q || (wr.wr_addr != exp_pc_q)) begin
                        op_load_d = 1'b1;
                        sw_d      = wr.wr_addr;
                    end else begin
                        op_load_d = 1'b0;
                        sw_d      = wr.wr_data;
                    end
                    state_d = OP_SETUP;
                    cnt_d   = phase_load(SETUP_CYC);
                end
            end
            OP_SETUP, FINAL_LOAD: begin
                if (tim_done) begin
                    state_d = OP_PULSE;
                    cnt_d   = phase_load(PULSE_CYC);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OP_PULSE: begin
                if (tim_done) begin
                    state_d = OP_GAP;
                    cnt_d   = phase_load(GAP_CYC);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OP_GAP: begin
                if (dep_done) begin
                    exp_pc_d  = addr_q + 1'b1;
                    exp_vld_d = 1'b1;
                    words_d   = sat_inc(words_q);
                    if (last_q) begin
                        final_d   = 1'b1;
                        op_load_d = 1'b1;
                        sw_d      = start_pc_q;
                        state_d   = FINAL_LOAD;
                        cnt_d     = phase_load(SETUP_CYC);
                    end else begin
                        state_d = WAIT_WORD;
                    end
                end else if (tim_done && final_q) begin
                    run_sw_d = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else if (tim_done) begin
                    op_load_d = 1'b0;
                    sw_d      = data_q;
                    state_d   = OP_SETUP;
                    cnt_d     = phase_load(SETUP_CYC);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Buttons are registered from the next state so they track OP_PULSE exactly
        load_btn_d = (state_d == OP_PULSE) && op_load_d;
        dep_btn_d  = (state_d == OP_PULSE) && !op_load_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sw_q       <= '0;
            load_btn_q <= 1'b0;
            dep_btn_q  <= 1'b0;
            run_sw_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            words_q    <= '0;
            exp_vld_q  <= 1'b0;
            op_load_q  <= 1'b0;
            final_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sw_q       <= sw_d;
            load_btn_q <= load_btn_d;
            dep_btn_q  <= dep_btn_d;
            run_sw_q   <= run_sw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            words_q    <= words_d;
            exp_vld_q  <= exp_vld_d;
            op_load_q  <= op_load_d;
            final_q    <= final_d;
        end
    end

    always_ff @(posedge clock) begin
        exp_pc_q   <= exp_pc_d;
        start_pc_q <= start_pc_d;
        addr_q     <= addr_d;
        data_q     <= data_d;
        last_q     <= last_d;
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q;

    always_ff @(posedge clock) begin
        if (reset || start_acc) begin
            csum_q <= '0;
        end else if (dep_done) begin
            csum_q <= csum_q + data_q;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign wr.wr_ready   = (state_q == WAIT_WORD);
    assign sw            = sw_q;
    assign load_pc_btn   = load_btn_q;
    assign deposit_btn   = dep_btn_q;
    assign run_sw        = run_sw_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_loaded  = words_q;

endmodule
